// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared cache geometry, address fields and state encodings
package cache_pkg;
  localparam int WORD_WIDTH        = 32;
  localparam int ADR_WIDTH         = 32;
  localparam int WORD_OFFSET_WIDTH = 2;
  localparam int WORD_NUM          = 4;

  localparam int ADR_WORD_OFFSET_BEGIN = 2;
  localparam int ADR_INDEX_BEGIN       = 4;
  localparam int ADR_TAG_END           = 31;

  typedef enum logic [1:0] {
    E_FREE,
    E_FILLING,
    E_FULL,
    E_DRAINING
  } entry_state_e;

  typedef enum logic {
    D_IDLE,
    D_REQ
  } drain_state_e;
endpackage

// File: rtl/wb_entry.sv
// rtl/wb_entry.sv - one buffered victim line: tag, words, valid mask, state
module wb_entry
  import cache_pkg::*;
#(
  parameter int DW = WORD_WIDTH,
  parameter int TW = ADR_WIDTH - ADR_INDEX_BEGIN,
  parameter int OW = WORD_OFFSET_WIDTH,
  parameter int NW = WORD_NUM
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [TW-1:0] wr_tag,
  input  logic [OW-1:0] wr_word,
  input  logic [DW-1:0] wr_dat,
  input  logic         start_drain,
  input  logic         free_en,
  input  logic [OW-1:0] rd_word,
  input  logic [TW-1:0] fwd_tag,
  input  logic [OW-1:0] fwd_word,
  output logic [DW-1:0] rd_dat,
  output logic [TW-1:0] tag,
  output entry_state_e state,
  output logic         tag_match,
  output logic         completes,
  output logic         fwd_hit,
  output logic [DW-1:0] fwd_dat
);

  logic [DW-1:0] data [NW];
  logic [NW-1:0] mask;
  logic [NW-1:0] next_mask;

  assign next_mask = mask | (NW'(1) << wr_word);
  // Whether a write this cycle would fill the last missing word.
  assign completes = &next_mask;
  assign tag_match = (tag == wr_tag);
  assign rd_dat    = data[rd_word];
  assign fwd_hit   = (state != E_FREE) && (tag == fwd_tag) && mask[fwd_word];
  assign fwd_dat   = fwd_hit ? data[fwd_word] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= E_FREE;
      tag   <= '0;
      mask  <= '0;
      for (int i = 0; i < NW; i++) data[i] <= '0;
    end else begin
      if (wr_en) begin
        data[wr_word] <= wr_dat;
        mask          <= next_mask;
        state         <= completes ? E_FULL : E_FILLING;
        if (state == E_FREE) tag <= wr_tag;
      end
      if (start_drain) state <= E_DRAINING;
      if (free_en) begin
        state <= E_FREE;
        mask  <= '0;
      end
    end
  end

endmodule

// File: rtl/victim_writeback_buffer.sv
// rtl/victim_writeback_buffer.sv - victim line collector, forwarder and word-by-word drainer
module victim_writeback_buffer
  import cache_pkg::*;
#(
  parameter int WORD_WIDTH        = cache_pkg::WORD_WIDTH,
  parameter int ADR_WIDTH         = cache_pkg::ADR_WIDTH,
  parameter int WORD_OFFSET_WIDTH = cache_pkg::WORD_OFFSET_WIDTH,
  parameter int WORD_NUM          = cache_pkg::WORD_NUM,
  parameter int ENTRIES           = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         vic_valid_i,
  input  logic [ADR_WIDTH-1:0]         vic_adr_i,
  input  logic [WORD_OFFSET_WIDTH-1:0] vic_word_i,
  input  logic [WORD_WIDTH-1:0]        vic_dat_i,
  output logic                         vic_ready_o,
  input  logic [ADR_WIDTH-1:0]         fwd_adr_i,
  output logic                         fwd_hit_o,
  output logic [WORD_WIDTH-1:0]        fwd_dat_o,
  output logic                         mem_wr_req_o,
  output logic [ADR_WIDTH-1:0]         mem_wr_adr_o,
  output logic [WORD_WIDTH-1:0]        mem_wr_dat_o,
  input  logic                         mem_wr_ack_i,
  output logic                         empty_o,
  output logic                         proto_err_o
);

  localparam int TAG_W = ADR_WIDTH - ADR_INDEX_BEGIN;
  localparam int PTR_W = $clog2(ENTRIES);
  localparam logic [WORD_OFFSET_WIDTH-1:0] LAST_WORD = WORD_OFFSET_WIDTH'(WORD_NUM - 1);

  logic [PTR_W-1:0] head, tail, head_next, tail_next;
  drain_state_e dstate, dstate_next;
  logic [WORD_OFFSET_WIDTH-1:0] cnt, cnt_next;
  logic proto_err, proto_err_next;

  entry_state_e st [ENTRIES];
  logic [TAG_W-1:0] e_tag [ENTRIES];
  logic [WORD_WIDTH-1:0] e_rd_dat [ENTRIES];
  logic [WORD_WIDTH-1:0] e_fwd_dat [ENTRIES];
  logic [ENTRIES-1:0] tag_match, completes, e_hit, wr_en, start_drain, free_en;

  logic [TAG_W-1:0] vic_tag, fwd_tag;
  logic [WORD_OFFSET_WIDTH-1:0] fwd_word;
  logic accept, tag_ok;
  logic unused_bits;

  assign vic_tag     = vic_adr_i[ADR_WIDTH-1:ADR_INDEX_BEGIN];
  assign fwd_tag     = fwd_adr_i[ADR_WIDTH-1:ADR_INDEX_BEGIN];
  assign fwd_word    = fwd_adr_i[ADR_WORD_OFFSET_BEGIN +: WORD_OFFSET_WIDTH];
  assign unused_bits = ^{vic_adr_i[ADR_INDEX_BEGIN-1:0], fwd_adr_i[ADR_WORD_OFFSET_BEGIN-1:0]};

  for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
    wb_entry #(
      .DW(WORD_WIDTH),
      .TW(TAG_W),
      .OW(WORD_OFFSET_WIDTH),
      .NW(WORD_NUM)
    ) u_entry (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (wr_en[g]),
      .wr_tag     (vic_tag),
      .wr_word    (vic_word_i),
      .wr_dat     (vic_dat_i),
      .start_drain(start_drain[g]),
      .free_en    (free_en[g]),
      .rd_word    (cnt),
      .fwd_tag    (fwd_tag),
      .fwd_word   (fwd_word),
      .rd_dat     (e_rd_dat[g]),
      .tag        (e_tag[g]),
      .state      (st[g]),
      .tag_match  (tag_match[g]),
      .completes  (completes[g]),
      .fwd_hit    (e_hit[g]),
      .fwd_dat    (e_fwd_dat[g])
    );
  end

  // Readiness only looks at registered entry state, so a line freed this
  // cycle is not reused until the next one.
  assign vic_ready_o = (st[tail] == E_FREE) || (st[tail] == E_FILLING);
  assign accept      = vic_valid_i && vic_ready_o;
  assign tag_ok      = (st[tail] == E_FREE) || tag_match[tail];

  always_comb begin
    wr_en          = '0;
    start_drain    = '0;
    free_en        = '0;
    tail_next      = tail;
    head_next      = head;
    dstate_next    = dstate;
    cnt_next       = cnt;
    proto_err_next = proto_err;

    if (accept) begin
      if (tag_ok) begin
        wr_en[tail] = 1'b1;
        if (completes[tail]) tail_next = tail + PTR_W'(1);
      end else begin
        proto_err_next = 1'b1;
      end
    end

    case (dstate)
      D_IDLE: begin
        if (st[head] == E_FULL) begin
          start_drain[head] = 1'b1;
          dstate_next       = D_REQ;
          cnt_next          = '0;
        end
      end
      D_REQ: begin
        if (mem_wr_ack_i) begin
          if (cnt == LAST_WORD) begin
            free_en[head] = 1'b1;
            head_next     = head + PTR_W'(1);
            dstate_next   = D_IDLE;
            cnt_next      = '0;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
      end
      default: dstate_next = D_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      dstate    <= D_IDLE;
      cnt       <= '0;
      proto_err <= 1'b0;
    end else begin
      head      <= head_next;
      tail      <= tail_next;
      dstate    <= dstate_next;
      cnt       <= cnt_next;
      proto_err <= proto_err_next;
    end
  end

  assign proto_err_o  = proto_err;
  assign mem_wr_req_o = (dstate == D_REQ);
  assign mem_wr_adr_o = mem_wr_req_o ? {e_tag[head], cnt, {ADR_WORD_OFFSET_BEGIN{1'b0}}} : '0;
  assign mem_wr_dat_o = mem_wr_req_o ? e_rd_dat[head] : '0;

  always_comb begin
    empty_o = 1'b1;
    for (int i = 0; i < ENTRIES; i++) begin
      if (st[i] != E_FREE) empty_o = 1'b0;
    end
  end

  // Walk oldest to newest so the entry nearest the tail wins on multiple hits.
  always_comb begin
    logic [PTR_W-1:0] idx;
    fwd_hit_o = 1'b0;
    fwd_dat_o = '0;
    idx       = '0;
    for (int k = 0; k < ENTRIES; k++) begin
      idx = tail + PTR_W'(k + 1);
      if (e_hit[idx]) begin
        fwd_hit_o = 1'b1;
        fwd_dat_o = e_fwd_dat[idx];
      end
    end
  end

endmodule

// File: tb/tb_victim_writeback_buffer.sv
// tb/tb_victim_writeback_buffer.sv - directed scoreboard bench for victim_writeback_buffer
module tb_victim_writeback_buffer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vic_valid = 1'b0;
  logic [31:0] vic_adr = '0;
  logic [1:0]  vic_word = '0;
  logic [31:0] vic_dat = '0;
  logic        vic_ready;
  logic [31:0] fwd_adr = '0;
  logic        fwd_hit;
  logic [31:0] fwd_dat;
  logic        mem_wr_req;
  logic [31:0] mem_wr_adr;
  logic [31:0] mem_wr_dat;
  logic        mem_wr_ack = 1'b0;
  logic        empty;
  logic        proto_err;

  int tests = 0;
  int fails = 0;
  logic [63:0] sb [$];

  victim_writeback_buffer dut (
    .clk         (clk),
    .rst         (rst),
    .vic_valid_i (vic_valid),
    .vic_adr_i   (vic_adr),
    .vic_word_i  (vic_word),
    .vic_dat_i   (vic_dat),
    .vic_ready_o (vic_ready),
    .fwd_adr_i   (fwd_adr),
    .fwd_hit_o   (fwd_hit),
    .fwd_dat_o   (fwd_dat),
    .mem_wr_req_o(mem_wr_req),
    .mem_wr_adr_o(mem_wr_adr),
    .mem_wr_dat_o(mem_wr_dat),
    .mem_wr_ack_i(mem_wr_ack),
    .empty_o     (empty),
    .proto_err_o (proto_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] adr, input logic [1:0] w, input logic [31:0] d);
    vic_valid = 1'b1;
    vic_adr   = adr;
    vic_word  = w;
    vic_dat   = d;
    step();
    vic_valid = 1'b0;
  endtask

  task automatic push_line(input logic [31:0] line, input logic [31:0] d0, input logic [31:0] d1,
                           input logic [31:0] d2, input logic [31:0] d3);
    sb.push_back({line,          d0});
    sb.push_back({line + 32'h4,  d1});
    sb.push_back({line + 32'h8,  d2});
    sb.push_back({line + 32'hC,  d3});
  endtask

  task automatic drain(input int n);
    int t;
    logic [63:0] exp;
    for (int i = 0; i < n; i++) begin
      t = 0;
      while (!mem_wr_req && t < 50) begin
        step();
        t++;
      end
      chk("req_wait", 64'(mem_wr_req), 64'h1);
      exp = (sb.size() > 0) ? sb.pop_front() : '1;
      chk("wr_adr", 64'(mem_wr_adr), 64'(exp[63:32]));
      chk("wr_dat", 64'(mem_wr_dat), 64'(exp[31:0]));
      mem_wr_ack = 1'b1;
      step();
      mem_wr_ack = 1'b0;
    end
  endtask

  initial begin
    logic [63:0] exp;
    int writes;
    int gaps;
    logic seen;

    repeat (3) step();
    rst = 1'b0;
    chk("rst_ready", 64'(vic_ready), 64'h1);
    chk("rst_hit", 64'(fwd_hit), 64'h0);
    chk("rst_fdat", 64'(fwd_dat), 64'h0);
    chk("rst_req", 64'(mem_wr_req), 64'h0);
    chk("rst_adr", 64'(mem_wr_adr), 64'h0);
    chk("rst_dat", 64'(mem_wr_dat), 64'h0);
    chk("rst_empty", 64'(empty), 64'h1);
    chk("rst_err", 64'(proto_err), 64'h0);

    // Out-of-order fill, in-order drain
    send(32'h1230, 2'd2, 32'hA2);
    send(32'h1230, 2'd0, 32'hA0);
    send(32'h1230, 2'd3, 32'hA3);
    send(32'h1230, 2'd1, 32'hA1);
    push_line(32'h1230, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
    chk("req_not_same_edge", 64'(mem_wr_req), 64'h0);
    step();
    chk("req_next_edge", 64'(mem_wr_req), 64'h1);
    drain(4);
    chk("l1_empty", 64'(empty), 64'h1);
    chk("l1_req_drop", 64'(mem_wr_req), 64'h0);

    // Two lines with no ack fill the buffer
    for (int i = 0; i < 4; i++) send(32'h2000, 2'(i), 32'hB200 + 32'(i));
    for (int i = 0; i < 4; i++) send(32'h3000, 2'(i), 32'hB300 + 32'(i));
    push_line(32'h2000, 32'hB200, 32'hB201, 32'hB202, 32'hB203);
    push_line(32'h3000, 32'hB300, 32'hB301, 32'hB302, 32'hB303);
    chk("full_ready", 64'(vic_ready), 64'h0);
    vic_valid = 1'b1;
    vic_adr   = 32'h7000;
    vic_word  = 2'd0;
    vic_dat   = 32'hDEAD;
    step();
    vic_valid = 1'b0;
    chk("full_no_err", 64'(proto_err), 64'h0);
    drain(4);
    chk("ready_after_free", 64'(vic_ready), 64'h1);
    drain(4);
    chk("l23_empty", 64'(empty), 64'h1);

    // Forwarding and protocol error on line 0x4000
    send(32'h4000, 2'd0, 32'hBAD0);
    send(32'h4000, 2'd0, 32'hC0);
    send(32'h4000, 2'd1, 32'hC1);
    fwd_adr = 32'h4004;
    #1;
    chk("fwd_hit_w1", 64'(fwd_hit), 64'h1);
    chk("fwd_dat_w1", 64'(fwd_dat), 64'hC1);
    fwd_adr = 32'h4000;
    #1;
    chk("fwd_dat_overwrite", 64'(fwd_dat), 64'hC0);
    fwd_adr = 32'h4008;
    #1;
    chk("fwd_miss_hit", 64'(fwd_hit), 64'h0);
    chk("fwd_miss_dat", 64'(fwd_dat), 64'h0);
    send(32'h5000, 2'd0, 32'hE0);
    chk("tag_err", 64'(proto_err), 64'h1);
    fwd_adr = 32'h5000;
    #1;
    chk("dropped_no_hit", 64'(fwd_hit), 64'h0);
    fwd_adr   = 32'h4008;
    vic_valid = 1'b1;
    vic_adr   = 32'h4000;
    vic_word  = 2'd2;
    vic_dat   = 32'hC2;
    #1;
    chk("same_cycle_no_fwd", 64'(fwd_hit), 64'h0);
    step();
    vic_valid = 1'b0;
    chk("next_cycle_fwd", 64'(fwd_dat), 64'hC2);
    send(32'h4000, 2'd3, 32'hC3);
    push_line(32'h4000, 32'hC0, 32'hC1, 32'hC2, 32'hC3);
    drain(4);
    chk("err_sticky", 64'(proto_err), 64'h1);
    chk("l4_empty", 64'(empty), 64'h1);

    // Reset in the middle of a drain
    for (int i = 0; i < 4; i++) send(32'h6000, 2'(i), 32'hD600 + 32'(i));
    push_line(32'h6000, 32'hD600, 32'hD601, 32'hD602, 32'hD603);
    drain(2);
    chk("mid_req", 64'(mem_wr_req), 64'h1);
    chk("mid_adr", 64'(mem_wr_adr), 64'h6008);
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb.delete();
    chk("rst_mid_req", 64'(mem_wr_req), 64'h0);
    chk("rst_mid_empty", 64'(empty), 64'h1);
    chk("rst_mid_ready", 64'(vic_ready), 64'h1);
    chk("rst_mid_err", 64'(proto_err), 64'h0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      seen = seen | mem_wr_req;
      step();
    end
    chk("rst_no_writes", 64'(seen), 64'h0);

    // Ack held high across two full lines: one bubble between lines
    for (int i = 0; i < 4; i++) send(32'h8000, 2'(i), 32'hF800 + 32'(i));
    for (int i = 0; i < 4; i++) send(32'h9000, 2'(i), 32'hF900 + 32'(i));
    push_line(32'h8000, 32'hF800, 32'hF801, 32'hF802, 32'hF803);
    push_line(32'h9000, 32'hF900, 32'hF901, 32'hF902, 32'hF903);
    mem_wr_ack = 1'b1;
    writes = 0;
    gaps   = 0;
    for (int c = 0; c < 12; c++) begin
      if (mem_wr_req) begin
        exp = (sb.size() > 0) ? sb.pop_front() : '1;
        chk("stream_adr", 64'(mem_wr_adr), 64'(exp[63:32]));
        chk("stream_dat", 64'(mem_wr_dat), 64'(exp[31:0]));
        writes++;
      end else if (writes > 0 && writes < 8) begin
        gaps++;
      end
      step();
    end
    mem_wr_ack = 1'b0;
    chk("stream_writes", 64'(writes), 64'd8);
    chk("stream_bubble", 64'(gaps), 64'd1);
    chk("stream_empty", 64'(empty), 64'h1);
    chk("stream_ready", 64'(vic_ready), 64'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
